// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Brief    : Runs one neural-network layer. For each neuron it fetches six
//            operands into the neuron buffer, starts the neuron controller,
//            waits for its result and writes it to the layer result register.
//            Optional WAIT watchdog with timeout_err port: LAYER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int DW          = 16,
    parameter int AW          = 8,
    parameter int NUM_NEURONS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          buf_wr_en,
    output logic [2:0]    buf_wr_idx,
    output logic [DW-1:0] buf_wr_data,
    output logic          neuron_ready,
    input  logic          neuron_done,
    input  logic [DW-1:0] neuron_result,
    output logic          res_wr_en,
    output logic [2:0]    res_idx,
    output logic [DW-1:0] res_data,
    output logic          layer_done
`ifdef LAYER_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_arm   = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_store = 3'd4;
    localparam logic [2:0] c_st_next  = 3'd5;
    localparam logic [2:0] c_st_done  = 3'd6;

    // Step 6 of FETCH issues no read; it only lands the data of the sixth read.
    localparam logic [2:0] c_last_k = 3'd6;
    localparam logic [2:0] c_last_n = 3'(NUM_NEURONS - 1);

    // Illegal parameter sets keep the block idle rather than running a bogus layer.
    localparam logic c_params_ok = (NUM_NEURONS >= 1) && (NUM_NEURONS <= 8) && (TIMEOUT >= 1);

    logic [2:0]    r_state;
    logic [2:0]    r_k;
    logic [2:0]    r_n;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_result;
    logic          w_accept;
    logic          w_timeout;

    assign w_accept = (r_state == c_st_idle) && start && c_params_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_k      <= 3'd0;
            r_n      <= 3'd0;
            r_addr   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_addr  <= base_addr;
                        r_n     <= 3'd0;
                        r_k     <= 3'd0;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    // r_addr walks base+6n+k, so the next neuron starts where this one ended.
                    if (r_k != c_last_k) begin
                        r_addr <= r_addr + 1'b1;
                        r_k    <= r_k + 3'd1;
                    end else begin
                        r_k     <= 3'd0;
                        r_state <= c_st_arm;
                    end
                end
                c_st_arm: r_state <= c_st_wait;
                c_st_wait: begin
                    if (neuron_done) begin
                        r_result <= neuron_result;
                        r_state  <= c_st_store;
                    end else if (w_timeout) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_store: r_state <= c_st_next;
                c_st_next: begin
                    if (r_n == c_last_n) begin
                        r_state <= c_st_done;
                    end else begin
                        r_n     <= r_n + 3'd1;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

`ifdef LAYER_TIMEOUT_EN
    localparam int              c_tw       = $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT - 1);

    logic [c_tw-1:0] r_wait_cnt;
    logic            r_timeout_err;

    assign w_timeout   = (r_state == c_st_wait) && !neuron_done && (r_wait_cnt == c_tmo_last);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != c_st_wait) begin
                r_wait_cnt <= '0;
            end else if (!neuron_done) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_accept) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign busy         = (r_state != c_st_idle) && (r_state != c_st_done);
    assign mem_rd_en    = (r_state == c_st_fetch) && (r_k != c_last_k);
    assign mem_addr     = r_addr;
    assign buf_wr_en    = (r_state == c_st_fetch) && (r_k != 3'd0);
    assign buf_wr_idx   = buf_wr_en ? (r_k - 3'd1) : 3'd0;
    assign buf_wr_data  = buf_wr_en ? mem_rd_data : '0;
    assign neuron_ready = (r_state == c_st_arm);
    assign res_wr_en    = (r_state == c_st_store);
    assign res_idx      = res_wr_en ? r_n : 3'd0;
    assign res_data     = res_wr_en ? r_result : '0;
    assign layer_done   = (r_state == c_st_done);

endmodule
`default_nettype wire
